// File: rtl/laser_tx_scheduler.sv
// -----------------------------------------------------------------------------
// laser_tx_scheduler
//
// Moves one packet from the packet buffer onto the dual-laser transmitter, one
// byte pair per transfer (byte 1 to laser 1, byte 2 to laser 2). After the last
// pair it waits for a single response byte from the laser receiver:
//   - ACK (8'h11) completes the packet (pkt_ok_o pulse).
//   - Any other byte, or no byte within TIMEOUT cycles, restarts the whole
//     packet from address 0, up to MAX_RETRY extra attempts; after that the
//     packet is abandoned (pkt_fail_o pulse).
//
// Handshake with the transmitter: tx_ready_o is high only in SEND, and the
// byte pair on tx_data1_o/tx_data2_o is stable for the whole SEND stay. The
// transmitter answers with a one-cycle tx_done_i pulse once the pair has gone
// out; the block leaves SEND on that same edge, so tx_ready_o is already low in
// the following cycle and the transmitter never sees the old pair as new.
//
// Ports:
//   clock_i              system clock
//   reset_i              asynchronous, active-high reset
//   start_i              one-cycle pulse, starts a packet when idle
//   abort_i              synchronous return to IDLE from any state
//   rd_addr_o  [AW-1:0]  packet buffer read address (byte-pair index)
//   rd_data1_i [7:0]     buffer byte for laser 1, valid 1 cycle after rd_addr_o
//   rd_data2_i [7:0]     buffer byte for laser 2, valid 1 cycle after rd_addr_o
//   tx_data1_o [7:0]     byte to transmitter, laser 1
//   tx_data2_o [7:0]     byte to transmitter, laser 2
//   tx_ready_o           byte pair valid (both transmitter ready inputs)
//   tx_en_o              transmitter enable (lasers on)
//   tx_done_i            transmitter pulse: byte pair finished
//   rx_valid_i           receiver byte strobe
//   rx_data_i  [7:0]     receiver byte
//   busy_o               high whenever the FSM is not in IDLE
//   pkt_ok_o             one-cycle pulse: packet acknowledged
//   pkt_fail_o           one-cycle pulse: retries exhausted
//   retry_ct_o [2:0]     retransmits used on the current or last packet
//   state_o    [2:0]     current FSM state (debug observation)
// -----------------------------------------------------------------------------
module laser_tx_scheduler #(
    parameter int PKT_PAIRS = 256,
    parameter int AW        = 8,
    parameter int TIMEOUT   = 40,
    parameter int MAX_RETRY = 3
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          abort_i,
    output logic [AW-1:0] rd_addr_o,
    input  logic [7:0]    rd_data1_i,
    input  logic [7:0]    rd_data2_i,
    output logic [7:0]    tx_data1_o,
    output logic [7:0]    tx_data2_o,
    output logic          tx_ready_o,
    output logic          tx_en_o,
    input  logic          tx_done_i,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_data_i,
    output logic          busy_o,
    output logic          pkt_ok_o,
    output logic          pkt_fail_o,
    output logic [2:0]    retry_ct_o,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LOAD      = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_RESP = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR   = AW'(PKT_PAIRS - 1);
    localparam logic [7:0]    TMO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [2:0]    RETRY_LIMIT = 3'(MAX_RETRY);
    localparam logic [7:0]    ACK_BYTE    = 8'h11;

    state_t        state_q,    state_d;
    logic [AW-1:0] rd_addr_q,  rd_addr_d;
    logic [7:0]    tx_data1_q, tx_data1_d;
    logic [7:0]    tx_data2_q, tx_data2_d;
    logic [7:0]    timer_q,    timer_d;
    logic [2:0]    retry_q,    retry_d;
    logic          pkt_ok_q,   pkt_ok_d;
    logic          pkt_fail_q, pkt_fail_d;
    logic          tx_en_q,    tx_en_d;
    logic          tx_ready_q, tx_ready_d;
    logic          busy_q,     busy_d;

    // Next-state logic. Status outputs are decoded from the next state so that
    // they are registered yet change on the same edge as the state itself.
    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        tx_data1_d = tx_data1_q;
        tx_data2_d = tx_data2_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        pkt_ok_d   = 1'b0;
        pkt_fail_d = 1'b0;

        if (abort_i) begin
            // Address and retry count are left as they are for inspection;
            // the next start clears them.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d   = S_FETCH;
                        rd_addr_d = '0;
                        retry_d   = '0;
                    end
                end

                // Address is already on the bus; this cycle absorbs the
                // one-cycle buffer read latency.
                S_FETCH: begin
                    state_d = S_LOAD;
                end

                S_LOAD: begin
                    tx_data1_d = rd_data1_i;
                    tx_data2_d = rd_data2_i;
                    state_d    = S_SEND;
                end

                S_SEND: begin
                    if (tx_done_i) begin
                        if (rd_addr_q == LAST_ADDR) begin
                            state_d = S_WAIT_RESP;
                            timer_d = '0;
                        end else begin
                            rd_addr_d = rd_addr_q + AW'(1);
                            state_d   = S_FETCH;
                        end
                    end
                end

                S_WAIT_RESP: begin
                    // Saturates so it can never wrap back below the limit.
                    if (timer_q != TMO_LAST) begin
                        timer_d = timer_q + 8'd1;
                    end
                    // ACK is tested first so that an ACK landing in the
                    // timeout cycle still completes the packet.
                    if (rx_valid_i && (rx_data_i == ACK_BYTE)) begin
                        pkt_ok_d = 1'b1;
                        state_d  = S_IDLE;
                    end else if (rx_valid_i || (timer_q == TMO_LAST)) begin
                        if (retry_q >= RETRY_LIMIT) begin
                            pkt_fail_d = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            retry_d   = retry_q + 3'd1;
                            rd_addr_d = '0;
                            state_d   = S_FETCH;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        tx_en_d    = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_SEND);
        tx_ready_d = (state_d == S_SEND);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            tx_data1_q <= '0;
            tx_data2_q <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_fail_q <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            tx_data1_q <= tx_data1_d;
            tx_data2_q <= tx_data2_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_fail_q <= pkt_fail_d;
            tx_en_q    <= tx_en_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign rd_addr_o  = rd_addr_q;
    assign tx_data1_o = tx_data1_q;
    assign tx_data2_o = tx_data2_q;
    assign tx_ready_o = tx_ready_q;
    assign tx_en_o    = tx_en_q;
    assign busy_o     = busy_q;
    assign pkt_ok_o   = pkt_ok_q;
    assign pkt_fail_o = pkt_fail_q;
    assign retry_ct_o = retry_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_laser_tx_scheduler
//
// Directed bench for laser_tx_scheduler with a 4-pair packet, 40-cycle response
// timeout and two allowed retransmits. A registered buffer model supplies the
// byte pairs; the transmitter is played inline, answering each tx_ready with a
// tx_done pulse 11 cycles later. Inputs change and outputs are sampled 1 ns
// after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_laser_tx_scheduler;

    localparam int PKT_PAIRS = 4;
    localparam int AW        = 8;
    localparam int TIMEOUT   = 40;
    localparam int MAX_RETRY = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT signals
    logic          start, abort, tx_done, rx_valid;
    logic [7:0]    rx_data;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data1, rd_data2, tx_data1, tx_data2;
    logic          tx_ready, tx_en, busy, pkt_ok, pkt_fail;
    logic [2:0]    retry_ct, state;

    laser_tx_scheduler #(
        .PKT_PAIRS (PKT_PAIRS),
        .AW        (AW),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .start_i    (start),
        .abort_i    (abort),
        .rd_addr_o  (rd_addr),
        .rd_data1_i (rd_data1),
        .rd_data2_i (rd_data2),
        .tx_data1_o (tx_data1),
        .tx_data2_o (tx_data2),
        .tx_ready_o (tx_ready),
        .tx_en_o    (tx_en),
        .tx_done_i  (tx_done),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .busy_o     (busy),
        .pkt_ok_o   (pkt_ok),
        .pkt_fail_o (pkt_fail),
        .retry_ct_o (retry_ct),
        .state_o    (state)
    );

    // packet contents: pair i = {2i+1, 2i+2}
    logic [7:0] exp1 [4] = '{8'h01, 8'h03, 8'h05, 8'h07};
    logic [7:0] exp2 [4] = '{8'h02, 8'h04, 8'h06, 8'h08};

    // buffer model: one cycle read latency
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    always @(posedge clk) begin
        rd_data1 <= mem1[rd_addr];
        rd_data2 <= mem2[rd_addr];
    end

    // pulse counters for the completion outputs
    int ok_cnt   = 0;
    int fail_cnt = 0;
    always @(posedge clk) begin
        if (pkt_ok === 1'b1)   ok_cnt   <= ok_cnt + 1;
        if (pkt_fail === 1'b1) fail_cnt <= fail_cnt + 1;
    end

    int n_checks = 0;
    int n_err    = 0;
    int exp_ok   = 0;
    int exp_fail = 0;

    // -------------------------------------------------------------------------
    // driver / checker tasks
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_ready(output logic seen);
        int n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            if (tx_ready === 1'b1) seen = 1'b1;
            else begin
                step();
                n++;
            end
        end
    endtask

    // Plays the transmitter for pairs first..last of the current attempt.
    task automatic send_pairs(input int first, input int last, input logic [2:0] exp_retry);
        logic seen;
        for (int i = first; i <= last; i++) begin
            wait_ready(seen);
            check($sformatf("tx_ready_seen[%0d]", i), 32'(seen), 32'd1);
            check($sformatf("rd_addr[%0d]", i), 32'(rd_addr), 32'(i));
            check($sformatf("tx_data1[%0d]", i), 32'(tx_data1), 32'(exp1[i]));
            check($sformatf("tx_data2[%0d]", i), 32'(tx_data2), 32'(exp2[i]));
            check($sformatf("tx_en_send[%0d]", i), 32'(tx_en), 32'd1);
            check($sformatf("retry_send[%0d]", i), 32'(retry_ct), 32'(exp_retry));
            repeat (10) step();
            check($sformatf("tx_ready_held[%0d]", i), 32'(tx_ready), 32'd1);
            check($sformatf("tx_data1_held[%0d]", i), 32'(tx_data1), 32'(exp1[i]));
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            check($sformatf("tx_ready_drop[%0d]", i), 32'(tx_ready), 32'd0);
        end
    endtask

    // Sends a receiver byte in cycle k of WAIT_RESP (caller is in cycle 0).
    task automatic respond(input int k, input logic [7:0] b);
        repeat (k) step();
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic expect_ok(input string tag, input logic [2:0] exp_retry);
        check({tag, "_pkt_ok"}, 32'(pkt_ok), 32'd1);
        check({tag, "_pkt_fail"}, 32'(pkt_fail), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_retry"}, 32'(retry_ct), 32'(exp_retry));
        step();
        check({tag, "_pkt_ok_1cyc"}, 32'(pkt_ok), 32'd0);
        check({tag, "_state_idle"}, 32'(state), 32'(ST_IDLE));
        exp_ok++;
        check({tag, "_ok_count"}, 32'(ok_cnt), 32'(exp_ok));
        check({tag, "_fail_count"}, 32'(fail_cnt), 32'(exp_fail));
    endtask

    // -------------------------------------------------------------------------
    // stimulus
    // -------------------------------------------------------------------------
    initial begin
        start    = 1'b0;
        abort    = 1'b0;
        tx_done  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = 8'h00;
        end
        for (int i = 0; i < 4; i++) begin
            mem1[i] = exp1[i];
            mem2[i] = exp2[i];
        end

        // reset state
        repeat (2) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_tx_data1", 32'(tx_data1), 32'd0);
        check("rst_retry", 32'(retry_ct), 32'd0);
        check("rst_pkt_ok", 32'(pkt_ok), 32'd0);
        check("rst_pkt_fail", 32'(pkt_fail), 32'd0);
        rst = 1'b0;
        step();

        // 1: clean packet, ACK 5 cycles after the last tx_done
        pulse_start();
        check("t1_state_fetch", 32'(state), 32'(ST_FETCH));
        check("t1_busy", 32'(busy), 32'd1);
        send_pairs(0, 3, 3'd0);
        check("t1_wait_tx_en", 32'(tx_en), 32'd0);
        check("t1_state_wait", 32'(state), 32'(ST_WAIT));
        respond(4, 8'h11);
        expect_ok("t1", 3'd0);

        // 2: no response, timeout after exactly 40 cycles, ACK on attempt 2
        pulse_start();
        send_pairs(0, 3, 3'd0);
        repeat (TIMEOUT - 1) step();
        check("t2_still_wait_c39", 32'(state), 32'(ST_WAIT));
        check("t2_tx_en_c39", 32'(tx_en), 32'd0);
        step();
        check("t2_refetch", 32'(state), 32'(ST_FETCH));
        check("t2_refetch_addr", 32'(rd_addr), 32'd0);
        check("t2_retry1", 32'(retry_ct), 32'd1);
        send_pairs(0, 3, 3'd1);
        respond(2, 8'h11);
        expect_ok("t2", 3'd1);

        // 3: every response is FAIL -> 3 transmissions then pkt_fail
        pulse_start();
        for (int a = 0; a <= MAX_RETRY; a++) begin
            send_pairs(0, 3, 3'(a));
            respond(3, 8'hbb);
            if (a < MAX_RETRY) begin
                check($sformatf("t3_refetch[%0d]", a), 32'(state), 32'(ST_FETCH));
                check($sformatf("t3_retry[%0d]", a), 32'(retry_ct), 32'(a + 1));
            end
        end
        check("t3_pkt_fail", 32'(pkt_fail), 32'd1);
        check("t3_pkt_ok", 32'(pkt_ok), 32'd0);
        check("t3_retry_final", 32'(retry_ct), 32'd2);
        check("t3_busy", 32'(busy), 32'd0);
        step();
        check("t3_pkt_fail_1cyc", 32'(pkt_fail), 32'd0);
        repeat (5) step();
        check("t3_stays_idle", 32'(tx_en), 32'd0);
        exp_fail++;
        check("t3_fail_count", 32'(fail_cnt), 32'(exp_fail));
        check("t3_ok_count", 32'(ok_cnt), 32'(exp_ok));

        // 4: ACK in the timeout cycle wins
        pulse_start();
        send_pairs(0, 3, 3'd0);
        respond(TIMEOUT - 1, 8'h11);
        expect_ok("t4", 3'd0);
        repeat (3) step();
        check("t4_no_refetch", 32'(busy), 32'd0);

        // 5: start+abort in IDLE, then abort during SEND of pair 2
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("t5_start_abort_idle", 32'(busy), 32'd0);
        pulse_start();
        send_pairs(0, 1, 3'd0);
        begin
            logic seen;
            wait_ready(seen);
            check("t5_pair2_ready", 32'(seen), 32'd1);
        end
        check("t5_pair2_addr", 32'(rd_addr), 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_idle", 32'(state), 32'(ST_IDLE));
        check("t5_abort_tx_en", 32'(tx_en), 32'd0);
        check("t5_abort_tx_ready", 32'(tx_ready), 32'd0);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_addr_held", 32'(rd_addr), 32'd2);
        repeat (5) step();
        check("t5_no_ok", 32'(ok_cnt), 32'(exp_ok));
        check("t5_no_fail", 32'(fail_cnt), 32'(exp_fail));
        pulse_start();
        check("t5_restart_addr", 32'(rd_addr), 32'd0);
        check("t5_restart_retry", 32'(retry_ct), 32'd0);
        send_pairs(0, 3, 3'd0);
        respond(1, 8'h11);
        expect_ok("t5", 3'd0);

        // 6: start and stray ACK while busy, then reset during WAIT_RESP
        pulse_start();
        send_pairs(0, 0, 3'd0);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        step();
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        check("t6_busy_start_addr", 32'(rd_addr), 32'd1);
        send_pairs(1, 3, 3'd0);
        respond(5, 8'h5a);
        check("t6_other_byte_retry", 32'(retry_ct), 32'd1);
        send_pairs(0, 3, 3'd1);
        repeat (10) step();
        check("t6_pre_reset_wait", 32'(state), 32'(ST_WAIT));
        rst = 1'b1;
        #2;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_state", 32'(state), 32'(ST_IDLE));
        check("t6_rst_retry", 32'(retry_ct), 32'd0);
        check("t6_rst_addr", 32'(rd_addr), 32'd0);
        check("t6_rst_tx_data1", 32'(tx_data1), 32'd0);
        check("t6_rst_tx_data2", 32'(tx_data2), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        repeat (60) step();
        check("t6_after_busy", 32'(busy), 32'd0);
        check("t6_after_ok_count", 32'(ok_cnt), 32'(exp_ok));
        check("t6_after_fail_count", 32'(fail_cnt), 32'(exp_fail));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // overall time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "time limit");
    end

endmodule
